// File: rtl/can_err_pkg.sv
// Shared types and constants for the CAN fault-confinement block.
package can_err_pkg;

  typedef enum logic [1:0] {
    FC_ACTIVE  = 2'd0,
    FC_PASSIVE = 2'd1,
    FC_BUS_OFF = 2'd2
  } fc_state_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_BIT   = 3'd1,
    ERR_STUFF = 3'd2,
    ERR_FORM  = 3'd3,
    ERR_ACK   = 3'd4,
    ERR_CRC   = 3'd5
  } err_code_e;

  localparam int ERR_BIT_IDX   = 4;
  localparam int ERR_STUFF_IDX = 3;
  localparam int ERR_FORM_IDX  = 2;
  localparam int ERR_ACK_IDX   = 1;
  localparam int ERR_CRC_IDX   = 0;

  localparam int TX_ERR_INC    = 8;
  localparam int RX_ERR_INC    = 1;
  localparam int REC_RESET_VAL = 119;

  // Highest-priority cause wins: bit > stuff > form > ack > crc.
  function automatic err_code_e prio_code(input logic [4:0] v);
    if (v[ERR_BIT_IDX])   return ERR_BIT;
    if (v[ERR_STUFF_IDX]) return ERR_STUFF;
    if (v[ERR_FORM_IDX])  return ERR_FORM;
    if (v[ERR_ACK_IDX])   return ERR_ACK;
    if (v[ERR_CRC_IDX])   return ERR_CRC;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/can_busoff_recovery.sv
// Counts runs of recessive sample points while in bus-off and pulses
// recovery_done on the bit that completes the final required sequence.
module can_busoff_recovery #(
  parameter int RECESSIVE_RUN = 11,
  parameter int RECOVERY_SEQS = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic sample_point,
  input  logic rx_bit,
  output logic recovery_done
);

  localparam int RUN_W = $clog2(RECESSIVE_RUN + 1);
  localparam int SEQ_W = $clog2(RECOVERY_SEQS + 1);

  logic [RUN_W-1:0] run_cnt;
  logic [SEQ_W-1:0] seq_cnt;
  logic             run_full;
  logic             seq_full;

  assign run_full      = (run_cnt == RUN_W'(RECESSIVE_RUN - 1));
  assign seq_full      = (seq_cnt == SEQ_W'(RECOVERY_SEQS - 1));
  assign recovery_done = enable & sample_point & rx_bit & run_full & seq_full;

  // Counters stay cleared whenever the node is not in bus-off.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      run_cnt <= '0;
      seq_cnt <= '0;
    end else if (sample_point) begin
      if (!rx_bit) begin
        run_cnt <= '0;
      end else if (run_full) begin
        run_cnt <= '0;
        seq_cnt <= seq_full ? '0 : seq_cnt + SEQ_W'(1);
      end else begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
    end
  end

endmodule

// File: rtl/can_error_manager.sv
// TEC/REC bookkeeping, fault confinement and error-frame request generation
// between the CAN error-detection stage and the MAC.
module can_error_manager
  import can_err_pkg::*;
#(
  parameter int CNT_W         = 9,
  parameter int WARN_LIMIT    = 96,
  parameter int PASSIVE_LIMIT = 128,
  parameter int BUSOFF_LIMIT  = 256,
  parameter int RECESSIVE_RUN = 11,
  parameter int RECOVERY_SEQS = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_point,
  input  logic             rx_bit,
  input  logic             tx_active,
  input  logic [4:0]       err_vec,
  input  logic             tx_success,
  input  logic             rx_success,
  input  logic             err_ack,
  output logic [CNT_W-1:0] tec,
  output logic [CNT_W-1:0] rec,
  output logic [1:0]       fc_state,
  output logic             error_warning,
  output logic             err_req,
  output logic [2:0]       err_code
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] WARN_L  = CNT_W'(WARN_LIMIT);
  localparam logic [CNT_W-1:0] PASS_L  = CNT_W'(PASSIVE_LIMIT);
  localparam logic [CNT_W-1:0] BOFF_L  = CNT_W'(BUSOFF_LIMIT);
  localparam logic [CNT_W-1:0] REC_RST = CNT_W'(REC_RESET_VAL);

  fc_state_e        state_q, state_d;
  err_code_e        code_q, code_d, new_code;
  logic [CNT_W-1:0] tec_q, tec_d, rec_q, rec_d;
  logic             warn_q, warn_d, req_q, req_d;
  logic [CNT_W:0]   tec_sum, rec_sum;
  logic [CNT_W-1:0] tec_inc, rec_inc;
  logic             bus_off, err_event, ack_exempt, recovery_done;

  can_busoff_recovery #(
    .RECESSIVE_RUN(RECESSIVE_RUN),
    .RECOVERY_SEQS(RECOVERY_SEQS)
  ) u_recovery (
    .clk          (clk),
    .rst          (rst),
    .enable       (bus_off),
    .sample_point (sample_point),
    .rx_bit       (rx_bit),
    .recovery_done(recovery_done)
  );

  assign bus_off    = (state_q == FC_BUS_OFF);
  assign err_event  = (|err_vec) && !bus_off;
  assign new_code   = prio_code(err_vec);
  assign ack_exempt = (state_q == FC_PASSIVE) && (new_code == ERR_ACK);

  assign tec_sum = {1'b0, tec_q} + (CNT_W+1)'(TX_ERR_INC);
  assign rec_sum = {1'b0, rec_q} + (CNT_W+1)'(RX_ERR_INC);
  assign tec_inc = tec_sum[CNT_W] ? CNT_MAX : tec_sum[CNT_W-1:0];
  assign rec_inc = rec_sum[CNT_W] ? CNT_MAX : rec_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FC_ACTIVE;
      tec_q   <= '0;
      rec_q   <= '0;
      warn_q  <= 1'b0;
      req_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      tec_q   <= tec_d;
      rec_q   <= rec_d;
      warn_q  <= warn_d;
      req_q   <= req_d;
      code_q  <= code_d;
    end
  end

  // An error in the same cycle as a success pulse wins; state follows next counters.
  always_comb begin
    state_d = state_q;
    tec_d   = tec_q;
    rec_d   = rec_q;
    req_d   = req_q;
    code_d  = code_q;
    if (bus_off) begin
      req_d  = 1'b0;
      code_d = ERR_NONE;
      if (recovery_done) begin
        tec_d   = '0;
        rec_d   = '0;
        state_d = FC_ACTIVE;
      end
    end else begin
      if (err_event) begin
        if (tx_active) begin
          if (!ack_exempt) tec_d = tec_inc;
        end else begin
          rec_d = rec_inc;
        end
      end else begin
        if (tx_success && (tec_q != '0)) tec_d = tec_q - CNT_W'(1);
        if (rx_success) begin
          if (rec_q >= PASS_L)     rec_d = REC_RST;
          else if (rec_q != '0)    rec_d = rec_q - CNT_W'(1);
        end
      end

      if (tec_d >= BOFF_L)                         state_d = FC_BUS_OFF;
      else if ((tec_d >= PASS_L) || (rec_d >= PASS_L)) state_d = FC_PASSIVE;
      else                                         state_d = FC_ACTIVE;

      // An ack in the same cycle as a new error clears and immediately re-arms.
      if (err_event && (!req_q || err_ack)) begin
        req_d  = 1'b1;
        code_d = new_code;
      end else if (err_ack && req_q) begin
        req_d  = 1'b0;
        code_d = ERR_NONE;
      end

      if (state_d == FC_BUS_OFF) begin
        req_d  = 1'b0;
        code_d = ERR_NONE;
      end
    end
    warn_d = (tec_d >= WARN_L) || (rec_d >= WARN_L);
  end

  assign tec           = tec_q;
  assign rec           = rec_q;
  assign fc_state      = state_q;
  assign error_warning = warn_q;
  assign err_req       = req_q;
  assign err_code      = code_q;

endmodule

// File: tb/tb_can_error_manager.sv
// Self-checking bench for can_error_manager: vector table plus hand-written
// sequences for counter thresholds, bus-off recovery and reset.
module tb_can_error_manager;
  import can_err_pkg::*;

  localparam int CNT_W = 9;

  typedef struct {
    logic       rst;
    logic       tx_active;
    logic [4:0] err_vec;
    logic       tx_success;
    logic       rx_success;
    logic       err_ack;
    logic       sample_point;
    logic       rx_bit;
  } stim_t;

  typedef struct {
    logic [CNT_W-1:0] tec;
    logic [CNT_W-1:0] rec;
    logic [1:0]       fc;
    logic             warn;
    logic             req;
    logic [2:0]       code;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             sample_point;
  logic             rx_bit;
  logic             tx_active;
  logic [4:0]       err_vec;
  logic             tx_success;
  logic             rx_success;
  logic             err_ack;
  logic [CNT_W-1:0] tec;
  logic [CNT_W-1:0] rec;
  logic [1:0]       fc_state;
  logic             error_warning;
  logic             err_req;
  logic [2:0]       err_code;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  can_error_manager #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_point (sample_point),
    .rx_bit       (rx_bit),
    .tx_active    (tx_active),
    .err_vec      (err_vec),
    .tx_success   (tx_success),
    .rx_success   (rx_success),
    .err_ack      (err_ack),
    .tec          (tec),
    .rec          (rec),
    .fc_state     (fc_state),
    .error_warning(error_warning),
    .err_req      (err_req),
    .err_code     (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk_stim(input logic r, input logic txa, input logic [4:0] ev,
                                    input logic txs, input logic rxs, input logic ack,
                                    input logic sp, input logic rxb);
    stim_t s;
    s.rst = r; s.tx_active = txa; s.err_vec = ev; s.tx_success = txs;
    s.rx_success = rxs; s.err_ack = ack; s.sample_point = sp; s.rx_bit = rxb;
    return s;
  endfunction

  function automatic exp_t mk_exp(input int t, input int r, input fc_state_e f,
                                  input logic w, input logic q, input err_code_e c);
    exp_t e;
    e.tec = CNT_W'(t); e.rec = CNT_W'(r); e.fc = f; e.warn = w; e.req = q; e.code = c;
    return e;
  endfunction

  task automatic checkOutput(input string name);
    exp_t e;
    check_cnt++;
    if (exp_q.size() == 0) begin
      $display("[TB] FAIL %s: scoreboard empty, no expected value", name);
      return;
    end
    e = exp_q.pop_front();
    if ({tec, rec, fc_state, error_warning, err_req, err_code} ===
        {e.tec, e.rec, e.fc, e.warn, e.req, e.code}) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got tec=%0d rec=%0d fc=%0d warn=%0b req=%0b code=%0d, want tec=%0d rec=%0d fc=%0d warn=%0b req=%0b code=%0d",
               name, tec, rec, fc_state, error_warning, err_req, err_code,
               e.tec, e.rec, e.fc, e.warn, e.req, e.code);
    end
  endtask

  task automatic applyStimulus(input stim_t s, input exp_t e, input string name);
    exp_q.push_back(e);
    rst          = s.rst;
    tx_active    = s.tx_active;
    err_vec      = s.err_vec;
    tx_success   = s.tx_success;
    rx_success   = s.rx_success;
    err_ack      = s.err_ack;
    sample_point = s.sample_point;
    rx_bit       = s.rx_bit;
    @(posedge clk);
    #1;
    rst = 1'b0; err_vec = '0; tx_success = 1'b0; rx_success = 1'b0;
    err_ack = 1'b0; sample_point = 1'b0;
    checkOutput(name);
  endtask

  // 32 transmit bit errors from tec = 0 with no acks; the 32nd lands in bus-off.
  task automatic busOffByTx(input int rec_v);
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(mk_stim(0, 1, 5'b10000, 0, 0, 0, 0, 1),
                    mk_exp(8*i, rec_v,
                           (i == 32) ? FC_BUS_OFF : ((i >= 16) ? FC_PASSIVE : FC_ACTIVE),
                           (8*i >= 96) || (rec_v >= 96), i < 32,
                           (i < 32) ? ERR_BIT : ERR_NONE),
                    $sformatf("busoff_err%0d", i));
    end
  endtask

  task automatic sendBit(input logic v, input logic done, input int rec_v, input string name);
    if (done)
      applyStimulus(mk_stim(0, 0, 5'b00000, 0, 0, 0, 1, v),
                    mk_exp(0, 0, FC_ACTIVE, 0, 0, ERR_NONE), name);
    else
      applyStimulus(mk_stim(0, 0, 5'b00000, 0, 0, 0, 1, v),
                    mk_exp(256, rec_v, FC_BUS_OFF, 1, 0, ERR_NONE), name);
  endtask

  // Full recovery; sequence index dom (if >= 0) is broken by a dominant 10th bit.
  task automatic recover(input int dom, input int rec_v);
    for (int s = 0; s < 128; s++) begin
      if (s == dom) begin
        for (int b = 0; b < 9; b++) sendBit(1'b1, 1'b0, rec_v, $sformatf("rec_s%0d_pre%0d", s, b));
        sendBit(1'b0, 1'b0, rec_v, $sformatf("rec_s%0d_dominant", s));
      end
      for (int b = 0; b < 11; b++)
        sendBit(1'b1, (s == 127) && (b == 10), rec_v, $sformatf("rec_s%0d_b%0d", s, b));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; tx_active = 1'b0; err_vec = '0; tx_success = 1'b0; rx_success = 1'b0;
    err_ack = 1'b0; sample_point = 1'b0; rx_bit = 1'b1;

    // Request/priority table, starting from tec = 127, rec = 0, ACTIVE.
    tbl.push_back('{mk_stim(0,0,5'b01001,0,0,0,0,1), mk_exp(127,1,FC_ACTIVE,1,1,ERR_STUFF)});
    tbl.push_back('{mk_stim(0,0,5'b00100,0,0,0,0,1), mk_exp(127,2,FC_ACTIVE,1,1,ERR_STUFF)});
    tbl.push_back('{mk_stim(0,0,5'b00000,0,0,1,0,1), mk_exp(127,2,FC_ACTIVE,1,0,ERR_NONE)});
    tbl.push_back('{mk_stim(0,0,5'b00000,0,0,1,0,1), mk_exp(127,2,FC_ACTIVE,1,0,ERR_NONE)});
    tbl.push_back('{mk_stim(0,0,5'b00010,0,0,0,0,1), mk_exp(127,3,FC_ACTIVE,1,1,ERR_ACK)});
    tbl.push_back('{mk_stim(0,0,5'b10000,0,0,1,0,1), mk_exp(127,4,FC_ACTIVE,1,1,ERR_BIT)});
    tbl.push_back('{mk_stim(0,0,5'b00001,0,1,0,0,1), mk_exp(127,5,FC_ACTIVE,1,1,ERR_BIT)});
    tbl.push_back('{mk_stim(0,0,5'b00000,0,0,1,0,1), mk_exp(127,5,FC_ACTIVE,1,0,ERR_NONE)});
    tbl.push_back('{mk_stim(0,0,5'b00000,0,1,0,0,1), mk_exp(127,4,FC_ACTIVE,1,0,ERR_NONE)});
    tbl.push_back('{mk_stim(0,0,5'b00000,1,1,0,0,1), mk_exp(126,3,FC_ACTIVE,1,0,ERR_NONE)});
    tbl.push_back('{mk_stim(0,0,5'b01000,0,0,0,0,1), mk_exp(126,4,FC_ACTIVE,1,1,ERR_STUFF)});
    tbl.push_back('{mk_stim(0,0,5'b00000,0,1,1,0,1), mk_exp(126,3,FC_ACTIVE,1,0,ERR_NONE)});
    tbl.push_back('{mk_stim(0,1,5'b00010,0,0,0,0,1), mk_exp(134,3,FC_PASSIVE,1,1,ERR_ACK)});
    tbl.push_back('{mk_stim(0,0,5'b00000,0,0,1,0,1), mk_exp(134,3,FC_PASSIVE,1,0,ERR_NONE)});

    applyStimulus(mk_stim(1,0,5'b00000,0,0,0,0,1), mk_exp(0,0,FC_ACTIVE,0,0,ERR_NONE), "reset");

    for (int i = 1; i <= 16; i++) begin
      applyStimulus(mk_stim(0,1,5'b10000,0,0,0,0,1),
                    mk_exp(8*i, 0, (i == 16) ? FC_PASSIVE : FC_ACTIVE, i >= 12, 1, ERR_BIT),
                    $sformatf("tx_err%0d", i));
      applyStimulus(mk_stim(0,1,5'b00000,0,0,1,0,1),
                    mk_exp(8*i, 0, (i == 16) ? FC_PASSIVE : FC_ACTIVE, i >= 12, 0, ERR_NONE),
                    $sformatf("tx_ack%0d", i));
    end
    applyStimulus(mk_stim(0,1,5'b00010,0,0,0,0,1), mk_exp(128,0,FC_PASSIVE,1,1,ERR_ACK), "passive_ack_err");
    applyStimulus(mk_stim(0,1,5'b00000,0,0,1,0,1), mk_exp(128,0,FC_PASSIVE,1,0,ERR_NONE), "passive_ack_clear");
    applyStimulus(mk_stim(0,1,5'b00000,1,0,0,0,1), mk_exp(127,0,FC_ACTIVE,1,0,ERR_NONE), "tx_success_to_active");

    for (int i = 0; i < tbl.size(); i++)
      applyStimulus(tbl[i].s, tbl[i].e, $sformatf("table%0d", i));

    applyStimulus(mk_stim(1,0,5'b00000,0,0,0,0,1), mk_exp(0,0,FC_ACTIVE,0,0,ERR_NONE), "reset2");
    applyStimulus(mk_stim(0,0,5'b00000,1,1,0,0,1), mk_exp(0,0,FC_ACTIVE,0,0,ERR_NONE), "floor_at_zero");

    for (int i = 1; i <= 130; i++)
      applyStimulus(mk_stim(0,0,5'b00001,0,0,0,0,1),
                    mk_exp(0, i, (i >= 128) ? FC_PASSIVE : FC_ACTIVE, i >= 96, 1, ERR_CRC),
                    $sformatf("rx_err%0d", i));
    applyStimulus(mk_stim(0,0,5'b00000,0,1,1,0,1), mk_exp(0,119,FC_ACTIVE,1,0,ERR_NONE), "rec_to_119");

    busOffByTx(119);
    applyStimulus(mk_stim(0,1,5'b11111,1,1,1,0,1), mk_exp(256,119,FC_BUS_OFF,1,0,ERR_NONE), "busoff_frozen");
    recover(49, 119);

    busOffByTx(0);
    for (int b = 0; b < 60*11 + 5; b++) sendBit(1'b1, 1'b0, 0, $sformatf("partial_b%0d", b));
    applyStimulus(mk_stim(1,0,5'b00000,0,0,0,1,1), mk_exp(0,0,FC_ACTIVE,0,0,ERR_NONE), "reset_in_busoff");
    busOffByTx(0);
    recover(-1, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
